// File: rtl/conv3x3_mac.sv
// 3x3 correlation MAC: nine signed Q-format taps against a runtime-loaded kernel,
// four-stage pipeline with round-half-up, saturation and end-of-line flagging.
module conv3x3_mac #(
   parameter int INTEGER_BITS     = 8,
   parameter int FIXED_POINT_BITS = 4,
   parameter int LINE_WIDTH       = 512
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst_n,
   input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]    i_kernel_data,
   input  logic                                        i_kernel_valid,
   output logic                                        o_kernel_ready,
   input  logic                                        i_kernel_reload,
   input  logic [9*(INTEGER_BITS+FIXED_POINT_BITS)-1:0] i_pixel_data,
   input  logic                                        i_pixel_data_valid,
   output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]    o_conv_data,
   output logic                                        o_conv_data_valid,
   output logic                                        o_line_done
);

   localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
   localparam int PW = 2 * W;
   localparam int SW = 2 * W + 4;
   localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

   localparam logic signed [SW-1:0] RND_C   = SW'(1) <<< (FIXED_POINT_BITS - 1);
   localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (W - 1)) - SW'(1);
   localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< (W - 1));

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state;
   logic [3:0]           idx;
   logic signed [W-1:0]  coef [9];
   logic signed [W-1:0]  px_p0 [9];
   logic                 vld_p0, vld_p1, vld_p2, vld_p3;
   logic signed [PW-1:0] prod_p1 [9];
   logic signed [SW-1:0] row_p2 [3];
   logic signed [SW-1:0] sum_p3;
   logic [CW-1:0]        line_cnt;

   // Round half toward +inf: bias by half an LSB, then floor via arithmetic shift.
   function automatic logic signed [SW-1:0] round_half_up(input logic signed [SW-1:0] s);
      return (s + RND_C) >>> FIXED_POINT_BITS;
   endfunction

   function automatic logic signed [W-1:0] saturate(input logic signed [SW-1:0] r);
      if (r > SAT_MAX)
         return SAT_MAX[W-1:0];
      else if (r < SAT_MIN)
         return SAT_MIN[W-1:0];
      else
         return r[W-1:0];
   endfunction

   always_comb begin
      for (int k = 0; k < 9; k++)
         px_p0[k] = i_pixel_data[k*W +: W];
   end

   assign vld_p0 = (state == RUN) && i_pixel_data_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= LOAD;
         idx            <= '0;
         o_kernel_ready <= 1'b1;
         for (int k = 0; k < 9; k++)
            coef[k] <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (i_kernel_valid) begin
                  coef[idx] <= i_kernel_data;
                  if (idx == 4'd8) begin
                     idx            <= '0;
                     state          <= RUN;
                     o_kernel_ready <= 1'b0;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            RUN: begin
               if (i_kernel_reload)
                  state <= DRAIN;
            end
            DRAIN: begin
               // The output stage needs no watching: once vld_p3 is clear it is final.
               if (!(vld_p1 || vld_p2 || vld_p3)) begin
                  state          <= LOAD;
                  idx            <= '0;
                  o_kernel_ready <= 1'b1;
               end
            end
            default: begin
               state          <= LOAD;
               idx            <= '0;
               o_kernel_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      // S1: products
      if (vld_p0) begin
         for (int k = 0; k < 9; k++)
            prod_p1[k] <= PW'(px_p0[k]) * PW'(coef[k]);
      end
      // S2: row partial sums
      if (vld_p1) begin
         for (int r = 0; r < 3; r++)
            row_p2[r] <= SW'(prod_p1[3*r]) + SW'(prod_p1[3*r+1]) + SW'(prod_p1[3*r+2]);
      end
      // S3: full sum
      if (vld_p2)
         sum_p3 <= row_p2[0] + row_p2[1] + row_p2[2];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p1            <= 1'b0;
         vld_p2            <= 1'b0;
         vld_p3            <= 1'b0;
         o_conv_data_valid <= 1'b0;
         o_conv_data       <= '0;
         o_line_done       <= 1'b0;
         line_cnt          <= '0;
      end else begin
         vld_p1            <= vld_p0;
         vld_p2            <= vld_p1;
         vld_p3            <= vld_p2;
         o_conv_data_valid <= vld_p3;
         // S4: round, saturate, line accounting
         if (vld_p3) begin
            o_conv_data <= saturate(round_half_up(sum_p3));
            if (line_cnt == CW'(LINE_WIDTH - 1)) begin
               line_cnt    <= '0;
               o_line_done <= 1'b1;
            end else begin
               line_cnt    <= line_cnt + CW'(1);
               o_line_done <= 1'b0;
            end
         end else begin
            o_line_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: directed corner cases plus random windows scored
// against an integer-arithmetic correlation model.
module tb_conv3x3_mac;

   localparam int W  = 12;
   localparam int LW = 512;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [W-1:0]   kd = '0;
   logic           kv = 1'b0;
   logic           kready;
   logic           reload = 1'b0;
   logic [9*W-1:0] pix = '0;
   logic           pv = 1'b0;
   logic [W-1:0]   cd;
   logic           cv;
   logic           ld;

   always #5 clk = ~clk;

   conv3x3_mac #(
      .INTEGER_BITS     (8),
      .FIXED_POINT_BITS (4),
      .LINE_WIDTH       (LW)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_kernel_data      (kd),
      .i_kernel_valid     (kv),
      .o_kernel_ready     (kready),
      .i_kernel_reload    (reload),
      .i_pixel_data       (pix),
      .i_pixel_data_valid (pv),
      .o_conv_data        (cd),
      .o_conv_data_valid  (cv),
      .o_line_done        (ld)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [W-1:0] mk [9];
   logic [9*W-1:0]      win_q [$];
   bit                  vld_q [$];
   bit                  obs_v [$];
   bit                  obs_ld [$];
   bit                  obs_rdy [$];
   logic [W-1:0]        obs_d [$];
   bit                  rdy_q [$];

   // Correlation of one window with the model kernel, in plain integers.
   function automatic logic [W-1:0] ref_pix(input logic [9*W-1:0] w);
      int acc;
      acc = 0;
      for (int p = 0; p < 9; p++)
         acc += int'($signed(w[p*W +: W])) * int'(mk[p]);
      acc = (acc + 8) >>> 4;
      if (acc > 2047)  acc = 2047;
      if (acc < -2048) acc = -2048;
      return acc[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_val(input int lim);
      int v;
      v = int'($urandom_range(2 * lim)) - lim;
      return v[W-1:0];
   endfunction

   function automatic logic [9*W-1:0] rnd_win(input int lim);
      logic [9*W-1:0] w;
      for (int p = 0; p < 9; p++)
         w[p*W +: W] = rnd_val(lim);
      return w;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; kv = 1'b0; reload = 1'b0; pv = 1'b0; pix = '0; kd = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load_kernel(input logic [W-1:0] k [9]);
      rdy_q.delete();
      for (int i = 0; i < 9; i++) begin
         kv = 1'b1; kd = k[i]; mk[i] = k[i];
         tick();
         rdy_q.push_back(kready);
      end
      kv = 1'b0; kd = '0;
   endtask

   // Drives win_q/vld_q back to back, then idles; records outputs once per cycle.
   task automatic run_stream(input int extra, input int rel_at);
      obs_v.delete(); obs_d.delete(); obs_ld.delete(); obs_rdy.delete();
      for (int c = 0; c < win_q.size() + extra; c++) begin
         if (c < win_q.size()) begin
            pv = vld_q[c]; pix = win_q[c];
         end else begin
            pv = 1'b0; pix = '0;
         end
         reload = (c == rel_at);
         tick();
         obs_v.push_back(cv); obs_d.push_back(cd);
         obs_ld.push_back(ld); obs_rdy.push_back(kready);
      end
      pv = 1'b0; reload = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (cv !== 1'b0)     begin n_bad++; $display("FAIL reset_valid: got %b want 0", cv); end
      n_cmp++; if (cd !== '0)       begin n_bad++; $display("FAIL reset_data: got %h want 000", cd); end
      n_cmp++; if (ld !== 1'b0)     begin n_bad++; $display("FAIL reset_line_done: got %b want 0", ld); end
      n_cmp++; if (kready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", kready); end
      rst_n = 1'b1;
   endtask

   task automatic test_identity();
      logic [W-1:0]   k [9];
      logic [9*W-1:0] w;
      do_reset();
      for (int i = 0; i < 9; i++) k[i] = '0;
      k[4] = 12'h010;
      load_kernel(k);
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (rdy_q[i] !== (i < 8)) begin
            n_bad++; $display("FAIL load_ready i=%0d: got %b want %b", i, rdy_q[i], (i < 8));
         end
      end
      w = {9{12'h3FF}};
      w[4*W +: W] = 12'h0A8;
      win_q = '{w}; vld_q = '{1'b1};
      run_stream(6, -1);
      for (int c = 0; c < 7; c++) begin
         n_cmp++;
         if (obs_v[c] !== (c == 3)) begin
            n_bad++; $display("FAIL identity_latency c=%0d: got %b want %b", c, obs_v[c], (c == 3));
         end
      end
      n_cmp++; if (obs_d[3] !== 12'h0A8) begin n_bad++; $display("FAIL identity_data: got %h want 0a8", obs_d[3]); end
      n_cmp++; if (obs_d[6] !== 12'h0A8) begin n_bad++; $display("FAIL identity_hold: got %h want 0a8", obs_d[6]); end
   endtask

   task automatic test_saturation();
      logic [W-1:0] k [9];
      do_reset();
      for (int i = 0; i < 9; i++) k[i] = 12'h010;
      load_kernel(k);
      win_q = '{{9{12'h7F0}}, {9{12'h800}}}; vld_q = '{1'b1, 1'b1};
      run_stream(5, -1);
      for (int c = 0; c < 7; c++) begin
         n_cmp++;
         if (obs_v[c] !== (c == 3 || c == 4)) begin
            n_bad++; $display("FAIL sat_valid c=%0d: got %b want %b", c, obs_v[c], (c == 3 || c == 4));
         end
      end
      n_cmp++; if (obs_d[3] !== 12'h7FF) begin n_bad++; $display("FAIL sat_pos: got %h want 7ff", obs_d[3]); end
      n_cmp++; if (obs_d[4] !== 12'h800) begin n_bad++; $display("FAIL sat_neg: got %h want 800", obs_d[4]); end
      n_cmp++; if (obs_d[6] !== 12'h800) begin n_bad++; $display("FAIL sat_hold: got %h want 800", obs_d[6]); end
   endtask

   task automatic test_rounding();
      logic [W-1:0]   k [9];
      logic [W-1:0]   want [3];
      logic [W-1:0]   p4 [4];
      logic [9*W-1:0] w;
      bit             ev;
      int             j;
      do_reset();
      for (int i = 0; i < 9; i++) k[i] = '0;
      k[4] = 12'h008;
      load_kernel(k);
      want = '{12'h001, 12'h000, 12'h002};
      p4   = '{12'h001, 12'hFFF, 12'h7FF, 12'h003};
      win_q.delete(); vld_q = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         w = rnd_win(2048);
         w[4*W +: W] = p4[i];
         win_q.push_back(w);
      end
      run_stream(4, -1);
      j = 0;
      for (int c = 0; c < 8; c++) begin
         ev = (c >= 3 && c - 3 < 4) ? vld_q[c-3] : 1'b0;
         n_cmp++;
         if (obs_v[c] !== ev) begin
            n_bad++; $display("FAIL round_valid c=%0d: got %b want %b", c, obs_v[c], ev);
         end
         if (ev) begin
            n_cmp++;
            if (obs_d[c] !== want[j]) begin
               n_bad++; $display("FAIL round_data c=%0d: got %h want %h", c, obs_d[c], want[j]);
            end
            j++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] k [9];
      bit           ev, eld;
      int           n;
      do_reset();
      for (int i = 0; i < 9; i++) k[i] = rnd_val(20);
      load_kernel(k);
      win_q.delete(); vld_q.delete();
      for (int i = 0; i < 2 * LW; i++) begin
         win_q.push_back(rnd_win(200)); vld_q.push_back(1'b1);
      end
      run_stream(5, -1);
      for (int c = 0; c < obs_v.size(); c++) begin
         ev  = (c >= 3 && c - 3 < 2 * LW);
         n   = c - 2;
         eld = ev && (n % LW == 0);
         n_cmp++;
         if (obs_v[c] !== ev) begin
            n_bad++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, obs_v[c], ev);
         end
         n_cmp++;
         if (obs_ld[c] !== eld) begin
            n_bad++; $display("FAIL b2b_line_done c=%0d: got %b want %b", c, obs_ld[c], eld);
         end
         if (ev) begin
            n_cmp++;
            if (obs_d[c] !== ref_pix(win_q[c-3])) begin
               n_bad++; $display("FAIL b2b_data c=%0d: got %h want %h", c, obs_d[c], ref_pix(win_q[c-3]));
            end
         end
      end
   endtask

   task automatic test_random_stream();
      logic [W-1:0] k [9];
      logic [W-1:0] last;
      bit           ev;
      do_reset();
      for (int i = 0; i < 9; i++) k[i] = ($urandom_range(3) == 0) ? rnd_val(2048) : rnd_val(20);
      load_kernel(k);
      win_q.delete(); vld_q.delete();
      for (int i = 0; i < 80; i++) begin
         win_q.push_back(rnd_win((i % 2 == 0) ? 200 : 2048));
         vld_q.push_back($urandom_range(3) != 0);
      end
      run_stream(5, -1);
      last = '0;
      for (int c = 0; c < obs_v.size(); c++) begin
         ev = (c >= 3 && c - 3 < 80) ? vld_q[c-3] : 1'b0;
         if (ev) last = ref_pix(win_q[c-3]);
         n_cmp++;
         if (obs_v[c] !== ev) begin
            n_bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, obs_v[c], ev);
         end
         n_cmp++;
         if (obs_d[c] !== last) begin
            n_bad++; $display("FAIL rand_data c=%0d: got %h want %h", c, obs_d[c], last);
         end
         n_cmp++;
         if (obs_ld[c] !== 1'b0) begin
            n_bad++; $display("FAIL rand_line_done c=%0d: got %b want 0", c, obs_ld[c]);
         end
      end
   endtask

   task automatic test_reload_drain();
      logic [W-1:0] k [9];
      bit           ev;
      do_reset();
      win_q.delete(); vld_q.delete();
      for (int i = 0; i < 5; i++) begin
         win_q.push_back(rnd_win(200)); vld_q.push_back(1'b1);
      end
      run_stream(4, -1);
      for (int c = 0; c < obs_v.size(); c++) begin
         n_cmp++;
         if (obs_v[c] !== 1'b0 || obs_rdy[c] !== 1'b1) begin
            n_bad++; $display("FAIL load_drop c=%0d: got valid=%b ready=%b want valid=0 ready=1", c, obs_v[c], obs_rdy[c]);
         end
      end
      for (int i = 0; i < 9; i++) k[i] = rnd_val(20);
      load_kernel(k);
      win_q.delete(); vld_q.delete();
      for (int i = 0; i < 8; i++) begin
         win_q.push_back(rnd_win(200)); vld_q.push_back(1'b1);
      end
      run_stream(4, 2);
      for (int c = 0; c < obs_v.size(); c++) begin
         ev = (c >= 3 && c <= 5);
         n_cmp++;
         if (obs_v[c] !== ev) begin
            n_bad++; $display("FAIL drain_valid c=%0d: got %b want %b", c, obs_v[c], ev);
         end
         n_cmp++;
         if (obs_rdy[c] !== (c >= 6)) begin
            n_bad++; $display("FAIL drain_ready c=%0d: got %b want %b", c, obs_rdy[c], (c >= 6));
         end
         if (ev) begin
            n_cmp++;
            if (obs_d[c] !== ref_pix(win_q[c-3])) begin
               n_bad++; $display("FAIL drain_data c=%0d: got %h want %h", c, obs_d[c], ref_pix(win_q[c-3]));
            end
         end
      end
      for (int i = 0; i < 9; i++) k[i] = rnd_val(20);
      load_kernel(k);
      win_q = '{rnd_win(200), rnd_win(200), rnd_win(200)}; vld_q = '{1'b1, 1'b1, 1'b1};
      run_stream(4, -1);
      for (int c = 0; c < obs_v.size(); c++) begin
         ev = (c >= 3 && c <= 5);
         n_cmp++;
         if (obs_v[c] !== ev) begin
            n_bad++; $display("FAIL newk_valid c=%0d: got %b want %b", c, obs_v[c], ev);
         end
         if (ev) begin
            n_cmp++;
            if (obs_d[c] !== ref_pix(win_q[c-3])) begin
               n_bad++; $display("FAIL newk_data c=%0d: got %h want %h", c, obs_d[c], ref_pix(win_q[c-3]));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] k [9];
      do_reset();
      for (int i = 0; i < 9; i++) k[i] = rnd_val(20);
      load_kernel(k);
      pv = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pix = rnd_win(200);
         tick();
      end
      n_cmp++; if (cv !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid: got %b want 1", cv); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (cv !== 1'b0)     begin n_bad++; $display("FAIL arst_valid: got %b want 0", cv); end
      n_cmp++; if (kready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", kready); end
      n_cmp++; if (cd !== '0)       begin n_bad++; $display("FAIL arst_data: got %h want 000", cd); end
      tick();
      pv = 1'b0;
      rst_n = 1'b1;
      win_q.delete(); vld_q.delete();
      for (int i = 0; i < 6; i++) begin
         win_q.push_back(rnd_win(200)); vld_q.push_back(1'b1);
      end
      run_stream(4, -1);
      for (int c = 0; c < obs_v.size(); c++) begin
         n_cmp++;
         if (obs_v[c] !== 1'b0 || obs_rdy[c] !== 1'b1) begin
            n_bad++; $display("FAIL arst_noload c=%0d: got valid=%b ready=%b want valid=0 ready=1", c, obs_v[c], obs_rdy[c]);
         end
      end
      for (int i = 0; i < 9; i++) k[i] = rnd_val(20);
      load_kernel(k);
      win_q = '{rnd_win(200), rnd_win(200)}; vld_q = '{1'b1, 1'b1};
      run_stream(4, -1);
      for (int c = 3; c <= 4; c++) begin
         n_cmp++;
         if (obs_v[c] !== 1'b1 || obs_d[c] !== ref_pix(win_q[c-3])) begin
            n_bad++; $display("FAIL arst_reload c=%0d: got valid=%b data=%h want valid=1 data=%h", c, obs_v[c], obs_d[c], ref_pix(win_q[c-3]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_random_stream();
      test_reload_drain();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Downstream consumer of the 3-line image buffer controller.
- Takes each 3x3 pixel window (9 fixed-point pixels, one window per valid cycle) and computes the 9-tap multiply-accumulate against a runtime-loadable kernel.
- Rounds and saturates the sum back to the pixel format, then hands one output pixel per window to the next stage.
- Flags the end of each output line.

Parameters:
- INTEGER_BITS, 8, integer bits of pixel/coefficient (signed Q format, includes sign)
- FIXED_POINT_BITS, 4, fractional bits of pixel/coefficient
- LINE_WIDTH, 512, output pixels per line; sets o_line_done period

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_kernel_data  in  W  one coefficient, W = INTEGER_BITS+FIXED_POINT_BITS
- i_kernel_valid  in  1  coefficient strobe, accepted only while o_kernel_ready=1
- o_kernel_ready  out  1  block is in LOAD and accepting coefficients
- i_kernel_reload  in  1  single-cycle request to replace the kernel
- i_pixel_data  in  9*W  window; pixel p at bits [p*W +: W], row=p/3 (0 = oldest line), col=p%3
- i_pixel_data_valid  in  1  window valid
- o_conv_data  out  W  result pixel, same Q format
- o_conv_data_valid  out  1  result valid
- o_line_done  out  1  one-cycle pulse with the LINE_WIDTH-th result of a line

Behaviour:
- Reset (async assert, sync release):
  - state=LOAD, coefficient index=0, all 9 coefficients=0.
  - Valid pipeline cleared, line counter=0.
  - o_conv_data=0, o_conv_data_valid=0, o_line_done=0, o_kernel_ready=1.
- State machine LOAD/RUN/DRAIN:
  - LOAD: o_kernel_ready=1. Each i_kernel_valid writes coef[idx] and increments idx. The write with idx=8 sets idx=0 and moves to RUN next cycle (o_kernel_ready=0). i_pixel_data_valid in LOAD is dropped: no output and no counter change. i_kernel_reload is ignored.
  - RUN: windows are accepted every cycle valid is high; no backpressure. i_kernel_valid is ignored. i_kernel_reload moves to DRAIN. A window valid in the same cycle as the reload is still accepted.
  - DRAIN: input windows are dropped. The pipeline finishes in-flight results. When the valid pipeline is empty, move to LOAD with idx=0. Coefficients keep their old values until overwritten.
- Arithmetic (all signed two's complement):
  - product p = pixel[p]*coef[p]: 2W bits, 2*FIXED_POINT_BITS fractional bits.
  - sum = sum of 9 products, sign-extended to 2W+4 bits; no overflow is possible.
  - Rounding: add 2^(FIXED_POINT_BITS-1), then arithmetic shift right FIXED_POINT_BITS (round half toward +inf).
  - Saturation: clamp to [-2^(W-1), 2^(W-1)-1], i.e. 0x800..0x7FF at defaults.
  - Correlation, not convolution: no kernel flip.
- Pipeline:
  - S1: register 9 products.
  - S2: register 3 row partial sums.
  - S3: register full sum.
  - S4: round, saturate, register output.
  - o_conv_data_valid follows an accepted window by exactly 4 cycles.
  - Full throughput: one result per cycle.
  - o_conv_data holds its last value when valid is low.
- Line counter:
  - Increments on each o_conv_data_valid.
  - When it equals LINE_WIDTH-1 with valid high: o_line_done=1 that same cycle, counter wraps to 0.
  - Survives DRAIN/LOAD; cleared only by reset.
- Reset mid-operation: in-flight windows are discarded immediately; the kernel must be reloaded.

Test Plan:
1. Reset, load coef4=0x010 (1.0), others 0; window pixel4=0x0A8, others 0x3FF -> o_conv_data=0x0A8, valid exactly 4 cycles after input; o_kernel_ready low after 9th coefficient.
2. All coef=0x010; all pixels=0x7F0 -> 0x7FF (positive saturation); all pixels=0x800 -> 0x800 (negative saturation).
3. Rounding: coef4=0x008 (0.5), others 0. pixel4=0x001 -> 0x001 (half rounds up); pixel4=0xFFF -> 0x000; pixel4=0x003 -> 0x002.
4. 512 back-to-back windows, then another 512 -> 1024 consecutive valid outputs; o_line_done high exactly on outputs 512 and 1024, low elsewhere.
5. Windows driven during LOAD -> no outputs. Assert i_kernel_reload with 3 windows in flight -> those 3 results appear. Windows during DRAIN are dropped. o_kernel_ready rises the cycle after the last in-flight result. New kernel applies to the next window.
6. Deassert i_rst_n asynchronously mid-stream (between clock edges) -> o_conv_data_valid=0, o_kernel_ready=1 immediately. After release, windows produce nothing until 9 coefficients are loaded.
